ecu_seq: RTL and testbench
==========================

# ecu_seq

Instruction sequencer for the execution control unit. It fetches the opcode and up to three operand bytes over the byte-wide memory port, then presents them to the decode block as `insn`/`d1`/`d2`/`d3`. It steps the decode stage index `is` through execution until the instruction retires. It sits between the PC unit, the memory port and the decode block, and owns all instruction-level sequencing.

## Interface
- `AW`, 16: address width of `pc` / `mem_addr`.
- `MAX_STG`, 7: last legal stage index; a forced retire occurs here.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `run` in 1: start/continue fetching; when low, the current instruction completes, then the block idles.
- `pc` in AW: current PC from the PC unit.
- `pc_inc` out 1: one-cycle pulse per accepted byte; the PC unit applies it at the same edge.
- `mem_req` out 1: byte read request.
- `mem_addr` out AW: request address, equal to `pc` combinationally.
- `mem_rdata` in 8: read data, valid with `mem_ack`.
- `mem_ack` in 1: read complete; may assert in the first cycle of `mem_req`.
- `insn`, `d1`, `d2`, `d3` out 8 each: registered opcode/operand bytes to decode.
- `len` in 2: operand byte count from decode, valid the cycle after `insn` loads.
- `is` out 3: stage index to decode.
- `stall` in 1: hold the current stage (LSU/ALU busy).
- `ex_done` in 1: decode flags the current stage as final.
- `retire` out 1: one-cycle pulse on the instruction's final stage.
- `busy` out 1: high in any state except IDLE.
- `fault` out 1: memory watchdog fault (see Configuration).

## Operation
- Reset: state IDLE; `insn`/`d1`/`d2`/`d3`/`is`/byte counter `cnt` cleared to 0; `mem_req`, `pc_inc`, `retire`, `busy`, `fault` all 0.
- IDLE: if `run`, go to OPC. Otherwise stay.
- OPC: `mem_req`=1. On `mem_ack`:
  - `insn`←`mem_rdata`, `d1..d3`←0, `cnt`←0, `pc_inc` pulse.
  - Go to OPR.
- OPR: `mem_req` = (`cnt`≠`len`).
  - On `mem_ack` with `cnt`≠`len`: `d[cnt+1]`←`mem_rdata`, `cnt`++, `pc_inc` pulse.
  - When `cnt`==`len`: go to EXEC with `is`=0, no request issued.
- EXEC, evaluated in this priority order:
  - `stall`: hold `is`. `stall` beats `ex_done` in the same cycle.
  - `ex_done`, or `is`==MAX_STG: `retire` pulse, `is`←0, next state OPC if `run` else IDLE.
  - Otherwise: `is`++.
- `mem_ack` with `mem_req` low is ignored. `d1..d3` beyond `len` stay 0.
- `run` deasserted mid-fetch or mid-exec: the instruction still completes and retires.
- `rst` asserted mid-operation: immediate asynchronous clear. `mem_req` drops without waiting for `mem_ack`. Any late ack is ignored.
- `cnt` is 2 bits. `len`≤3 guarantees no wrap.

## Timing
- Zero-wait memory, `len`=L, S exec cycles:
  - From `run` rising in IDLE to `retire`: 1 + 1 + (L+1) + S cycles.
  - Back-to-back instructions: 1 + (L+1) + S cycles each.
- Each memory wait cycle adds one cycle. `mem_addr` stays stable while `mem_req` is high and un-acked.
- Consecutive byte requests are back-to-back: `pc` advances at the acking edge, so the next cycle's `mem_addr` is already the next byte.
- `insn`/`d*`/`is` change only at clock edges. Decode sees stable values for the full cycle.

## Configuration
- `ECU_SEQ_WDT_EN` defined:
  - An 8-bit counter increments each cycle `mem_req` is high without `mem_ack`, and clears on ack or when the request drops.
  - On reaching 255: enter FAULT, `fault`=1, `mem_req`=0, `busy`=1.
  - FAULT is sticky until `rst`.
- Not defined: no counter; `fault` tied 0; the block waits indefinitely for `mem_ack`.

## Structure
- Shared package `ecu_pkg`:
  - State encoding (IDLE, OPC, OPR, EXEC, FAULT).
  - `MAX_STG` default.
  - `WDT_LIMIT`=255.
  - Operand count width (2).
- One sub-module, `ecu_seq_wdt`: the watchdog counter, instantiated only under `ECU_SEQ_WDT_EN`.

## Test plan
- Reset check: hold `rst`=0, then release with `run`=0 → all outputs 0, `busy`=0; state stays IDLE for 10 cycles.
- 3-operand fetch:
  - Stimulus: `run`=1, zero-wait memory returning 13, 100, 50, 64; decode gives `len`=3 and `ex_done` at `is`=2.
  - Response: `insn`=13, `d1`=100, `d2`=50, `d3`=64; four `pc_inc` pulses; `is` 0→1→2; `retire` at cycle 9.
- 0-operand fetch:
  - Stimulus: opcode 5, `len`=0, `ex_done` at `is`=0.
  - Response: `d1..d3`=0; one `pc_inc`; `retire` 4 cycles after `run`.
- Stall and `run` drop:
  - Stimulus: `stall`=1 for 3 cycles at `is`=1, with `ex_done` high in the middle stalled cycle; `run` dropped during exec.
  - Response: `is` holds at 1; retire only after `stall` falls; block returns to IDLE.
- Forced retire and reset mid-fetch:
  - Stimulus: `ex_done` never asserts. Separately, assert `rst` while `mem_req`=1 with a 2-cycle ack delay.
  - Response: `retire` fires at `is`=7. The reset drops `mem_req` in the same cycle, and the late ack is ignored.
- Watchdog (`ECU_SEQ_WDT_EN`): `mem_ack` held at 0 → `fault`=1 after 255 request cycles; `mem_req`=0; state sticky until `rst`.

Source files
------------

// File: rtl/ecu_pkg.sv
// ecu_pkg: shared definitions for the execution control unit sequencer.
//   - ecu_state_e : sequencer state encoding
//   - MAX_STG_DEF : default last legal decode stage index
//   - WDT_LIMIT   : memory watchdog trip count
//   - CNT_W       : operand byte counter width
package ecu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_OPC   = 3'd1,
        ST_OPR   = 3'd2,
        ST_EXEC  = 3'd3,
        ST_FAULT = 3'd4
    } ecu_state_e;

    localparam int unsigned MAX_STG_DEF = 7;
    localparam int unsigned WDT_LIMIT   = 255;
    localparam int unsigned CNT_W       = 2;

endpackage

// File: rtl/ecu_seq_wdt.sv
// ecu_seq_wdt: memory watchdog for ecu_seq.
// Counts cycles in which a byte request is outstanding without an ack and
// clears on ack or when the request drops.
// Ports:
//   clk  in  : clock, rising edge
//   rst  in  : asynchronous active-low reset
//   req  in  : memory request from the sequencer
//   ack  in  : memory acknowledge
//   trip out : high in the un-acked cycle that takes the count to WDT_LIMIT
module ecu_seq_wdt
    import ecu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic ack,
    output logic trip
);

    logic [7:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (req && !ack) begin
            cnt_q <= cnt_q + 8'd1;
        end else begin
            cnt_q <= '0;
        end
    end

    // Tripping one count early lets the sequencer enter FAULT on the same
    // edge at which the counter reaches the limit.
    assign trip = req && !ack && (cnt_q == 8'(WDT_LIMIT - 1));

endmodule

// File: rtl/ecu_seq.sv
// ecu_seq: instruction sequencer for the execution control unit.
// Fetches an opcode and up to three operand bytes over the byte-wide memory
// port, presents them to decode, then steps the stage index until retire.
// Optional feature: define ECU_SEQ_WDT_EN to enable the memory watchdog
// (sticky FAULT state after WDT_LIMIT un-acked request cycles).
// Ports:
//   clk, rst            : clock (rising) / asynchronous active-low reset
//   run                 : start/continue fetching
//   pc / pc_inc         : current PC in / advance pulse out (one per byte)
//   mem_req, mem_addr   : byte read request and address (= pc)
//   mem_rdata, mem_ack  : read data and completion
//   insn, d1, d2, d3    : registered opcode and operand bytes to decode
//   len                 : operand byte count from decode
//   is                  : decode stage index
//   stall, ex_done      : hold current stage / current stage is final
//   retire, busy, fault : final-stage pulse / not idle / watchdog fault
module ecu_seq
    import ecu_pkg::*;
#(
    parameter int unsigned AW      = 16,
    parameter int unsigned MAX_STG = MAX_STG_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [AW-1:0]    pc,
    output logic             pc_inc,
    output logic             mem_req,
    output logic [AW-1:0]    mem_addr,
    input  logic [7:0]       mem_rdata,
    input  logic             mem_ack,
    output logic [7:0]       insn,
    output logic [7:0]       d1,
    output logic [7:0]       d2,
    output logic [7:0]       d3,
    input  logic [CNT_W-1:0] len,
    output logic [2:0]       is,
    input  logic             stall,
    input  logic             ex_done,
    output logic             retire,
    output logic             busy,
    output logic             fault
);

    ecu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       is_d;
    logic             load_opc;
    logic             load_opr;
    logic             wdt_trip;

`ifdef ECU_SEQ_WDT_EN
    ecu_seq_wdt u_wdt (
        .clk  (clk),
        .rst  (rst),
        .req  (mem_req),
        .ack  (mem_ack),
        .trip (wdt_trip)
    );
    assign fault = (state_q == ST_FAULT);
`else
    assign wdt_trip = 1'b0;
    assign fault    = 1'b0;
`endif

    assign mem_addr = pc;
    assign busy     = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        is_d     = is;
        mem_req  = 1'b0;
        pc_inc   = 1'b0;
        retire   = 1'b0;
        load_opc = 1'b0;
        load_opr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) state_d = ST_OPC;
            end
            ST_OPC: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    pc_inc   = 1'b1;
                    load_opc = 1'b1;
                    state_d  = ST_OPR;
                end else if (wdt_trip) begin
                    state_d = ST_FAULT;
                end
            end
            ST_OPR: begin
                if (cnt_q != len) begin
                    mem_req = 1'b1;
                    if (mem_ack) begin
                        pc_inc   = 1'b1;
                        load_opr = 1'b1;
                    end else if (wdt_trip) begin
                        state_d = ST_FAULT;
                    end
                end else begin
                    is_d    = '0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // stall outranks ex_done and the forced retire at MAX_STG
                if (!stall) begin
                    if (ex_done || (is == 3'(MAX_STG))) begin
                        retire  = 1'b1;
                        is_d    = '0;
                        state_d = run ? ST_OPC : ST_IDLE;
                    end else begin
                        is_d = is + 3'd1;
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            insn  <= '0;
            d1    <= '0;
            d2    <= '0;
            d3    <= '0;
            cnt_q <= '0;
            is    <= '0;
        end else begin
            is <= is_d;
            if (load_opc) begin
                insn  <= mem_rdata;
                d1    <= '0;
                d2    <= '0;
                d3    <= '0;
                cnt_q <= '0;
            end else if (load_opr) begin
                case (cnt_q)
                    2'd0:    d1 <= mem_rdata;
                    2'd1:    d2 <= mem_rdata;
                    default: d3 <= mem_rdata;
                endcase
                cnt_q <= cnt_q + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_ecu_seq.sv
module tb_ecu_seq;

    logic        clk;
    logic        rst;
    logic        run;
    logic [15:0] pc;
    logic        pc_inc;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [7:0]  insn, d1, d2, d3;
    logic [1:0]  len;
    logic [2:0]  is;
    logic        stall;
    logic        ex_done;
    logic        retire;
    logic        busy;
    logic        fault;

    // memory / decode models
    logic [7:0]  mem [0:255];
    int          ack_delay;
    int          wcnt;
    logic        ack_man;
    logic        done_en;
    logic [2:0]  done_stg;
    logic        ex_man;

    int n_chk;
    int n_pass;
    int lat;
    int incs;
    int cyc;
    int reqc;
    logic found;

    ecu_seq #(.AW(16), .MAX_STG(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .pc        (pc),
        .pc_inc    (pc_inc),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .insn      (insn),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .len       (len),
        .is        (is),
        .stall     (stall),
        .ex_done   (ex_done),
        .retire    (retire),
        .busy      (busy),
        .fault     (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_rdata = mem[pc[7:0]];
    assign mem_ack   = (mem_req && (wcnt >= ack_delay)) || ack_man;
    assign ex_done   = (done_en && (is == done_stg)) || ex_man;

    // PC unit model
    always @(posedge clk or negedge rst) begin
        if (!rst) pc <= 16'd0;
        else if (pc_inc) pc <= pc + 16'd1;
    end

    // memory wait-state model
    always @(posedge clk or negedge rst) begin
        if (!rst) wcnt <= 0;
        else if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // run is raised by the caller in cycle 0; latency counts edges up to and
    // including the edge that ends the retire cycle
    task automatic wait_retire(input int budget, output int l, output int n);
        l = -1;
        n = 0;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (pc_inc) n++;
            if (retire) begin
                l = k + 1;
                run = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1'b0; run = 1'b0; len = 2'd0; stall = 1'b0;
        ack_delay = 0; ack_man = 1'b0;
        done_en = 1'b0; done_stg = 3'd0; ex_man = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'hEE;
        mem[0] = 8'd13; mem[1] = 8'd100; mem[2] = 8'd50; mem[3] = 8'd64;
        mem[4] = 8'd5;
        mem[5] = 8'd9;  mem[6] = 8'd77;
        mem[7] = 8'd3;
        mem[8] = 8'd21; mem[9] = 8'd42;

        // reset state
        repeat (3) tick();
        check("rst_mem_req", mem_req, 0);
        check("rst_busy", busy, 0);
        check("rst_fault", fault, 0);
        rst = 1'b1;
        cyc = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (busy || mem_req || pc_inc || retire) cyc++;
        end
        check("idle_active_cycles", cyc, 0);
        check("idle_insn", insn, 0);
        check("idle_is", is, 0);

        // 3-operand fetch, ex_done at is=2
        len = 2'd3; done_en = 1'b1; done_stg = 3'd2;
        run = 1'b1;
        wait_retire(40, lat, incs);
        check("op3_latency", lat, 9);
        check("op3_pc_inc", incs, 4);
        check("op3_insn", insn, 13);
        check("op3_d1", d1, 100);
        check("op3_d2", d2, 50);
        check("op3_d3", d3, 64);
        check("op3_is_at_retire", is, 2);
        tick();
        check("op3_idle", busy, 0);

        // 0-operand fetch
        len = 2'd0; done_stg = 3'd0;
        run = 1'b1;
        wait_retire(40, lat, incs);
        check("op0_latency", lat, 4);
        check("op0_pc_inc", incs, 1);
        check("op0_insn", insn, 5);
        check("op0_d1", d1, 0);
        check("op0_d2", d2, 0);
        check("op0_d3", d3, 0);
        tick();

        // stall with ex_done in the middle stalled cycle, run dropped
        len = 2'd1; done_en = 1'b0;
        run = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            tick();
            if (is == 3'd1) found = 1'b1;
        end
        check("stall_reach_is1", found, 1);
        stall = 1'b1; run = 1'b0; #1;
        check("stall_c0_retire", retire, 0);
        tick(); ex_man = 1'b1; #1;
        check("stall_c1_is", is, 1);
        check("stall_c1_retire", retire, 0);
        tick(); ex_man = 1'b0; #1;
        check("stall_c2_is", is, 1);
        tick(); stall = 1'b0; ex_man = 1'b1; #1;
        check("stall_release_retire", retire, 1);
        check("stall_release_is", is, 1);
        tick(); ex_man = 1'b0;
        check("stall_idle", busy, 0);
        check("stall_is_cleared", is, 0);
        check("stall_insn", insn, 9);
        check("stall_d1", d1, 77);

        // forced retire at MAX_STG
        len = 2'd0;
        run = 1'b1;
        wait_retire(40, lat, incs);
        check("force_latency", lat, 11);
        check("force_is", is, 7);
        check("force_insn", insn, 3);
        tick();

        // one wait state per byte
        len = 2'd1; done_en = 1'b1; done_stg = 3'd0; ack_delay = 1;
        run = 1'b1;
        wait_retire(40, lat, incs);
        check("wait_latency", lat, 7);
        check("wait_insn", insn, 21);
        check("wait_d1", d1, 42);
        tick();

        // reset mid-fetch with a 2-cycle ack delay, then a stray late ack
        ack_delay = 2; len = 2'd0;
        run = 1'b1;
        tick();
        check("rstmid_req", mem_req, 1);
        check("rstmid_addr", mem_addr, 32'(pc));
        tick();
        check("rstmid_req_held", mem_req, 1);
        rst = 1'b0; run = 1'b0; #1;
        check("rstmid_req_drop", mem_req, 0);
        check("rstmid_busy", busy, 0);
        tick();
        rst = 1'b1;
        tick();
        ack_man = 1'b1; #1;
        check("late_ack_pc_inc", pc_inc, 0);
        tick();
        ack_man = 1'b0;
        check("late_ack_busy", busy, 0);
        check("late_ack_insn", insn, 0);

`ifdef ECU_SEQ_WDT_EN
        // watchdog: memory never acks
        ack_delay = 1000000;
        run = 1'b1;
        reqc = 0;
        for (int k = 0; k < 400; k++) begin
            tick();
            if (fault) break;
            if (mem_req) reqc++;
        end
        check("wdt_fault", fault, 1);
        check("wdt_req_cycles", reqc, 255);
        check("wdt_req_low", mem_req, 0);
        check("wdt_busy", busy, 1);
        run = 1'b0;
        repeat (5) tick();
        check("wdt_sticky", fault, 1);
        rst = 1'b0; #1;
        check("wdt_rst_clear", fault, 0);
        tick();
        rst = 1'b1;
`endif

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
